// File: rtl/pc_gen.sv
// Fetch program-counter generator: start/halt FSM, imem handshake, trap/branch redirects with a pending latch.
// Optional compressed-instruction support is enabled by defining PC_GEN_RVC_EN.
//
// state | meaning
// IDLE  | out of reset, not fetching, redirects ignored
// RUN   | fetching; pc advances or is redirected on if_ready
// HALT  | stopped by halt; pc held, pending redirect dropped
module pc_gen #(
    parameter int unsigned        XLEN      = 64,
    parameter logic [XLEN-1:0]    RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            halt,
    input  logic            if_ready,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_taken,
    input  logic [XLEN-1:0] trap_target,
    input  logic            is_rvc,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect,
    output logic            misalign_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;
    logic            pend_v_q, pend_v_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] align_mask;
    logic [XLEN-1:0] sel_tgt;
    logic            new_req;

`ifdef PC_GEN_RVC_EN
    assign step       = is_rvc ? XLEN'(2) : XLEN'(4);
    assign align_mask = XLEN'(1);
`else
    assign step       = XLEN'(4);
    assign align_mask = XLEN'(3);
    logic unused_rvc;
    assign unused_rvc = is_rvc;
`endif

    assign new_req = trap_taken | br_taken;

    // Trap beats branch beats an older pending request.
    always_comb begin
        sel_tgt = pend_tgt_q;
        if (trap_taken) begin
            sel_tgt = trap_target;
        end else if (br_taken) begin
            sel_tgt = br_target;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        pend_v_d   = pend_v_q;
        pend_tgt_d = pend_tgt_q;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_d  = HALT;
                    pend_v_d = 1'b0;
                end else if (if_ready && (new_req || pend_v_q)) begin
                    pc_d       = sel_tgt & ~align_mask;
                    misalign_d = |(sel_tgt & align_mask);
                    redirect_d = 1'b1;
                    pend_v_d   = 1'b0;
                end else if (!if_ready && new_req) begin
                    pend_v_d   = 1'b1;
                    pend_tgt_d = sel_tgt;
                end else if (if_ready && !stall) begin
                    pc_d = pc_q + step;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pc_valid_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
            pend_v_q   <= pend_v_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign redirect     = redirect_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (XLEN=64, RESET_VEC=0); expectations follow PC_GEN_RVC_EN.
module tb_pc_gen;

    localparam int XLEN = 64;

    logic            clk;
    logic            rstn;
    logic            start;
    logic            halt;
    logic            if_ready;
    logic            stall;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            trap_taken;
    logic [XLEN-1:0] trap_target;
    logic            is_rvc;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            redirect;
    logic            misalign_err;

    int tests_run;
    int tests_failed;

    pc_gen #(.XLEN(XLEN), .RESET_VEC('0)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .halt         (halt),
        .if_ready     (if_ready),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .trap_taken   (trap_taken),
        .trap_target  (trap_target),
        .is_rvc       (is_rvc),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .redirect     (redirect),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; halt = 1'b0; if_ready = 1'b0; stall = 1'b0;
        br_taken = 1'b0; br_target = '0; trap_taken = 1'b0; trap_target = '0; is_rvc = 1'b0;
        #12;
        tests_run++;
        if (pc !== 64'h0 || pc_valid !== 1'b0 || redirect !== 1'b0 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: pc=%h valid=%b redir=%b mis=%b, want pc=0 valid=0 redir=0 mis=0",
                     pc, pc_valid, redirect, misalign_err);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tests_run++;
        if (pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_fetch: pc_valid=%b want 0", pc_valid);
        end
    endtask

    task automatic test_start();
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (pc_valid !== 1'b1 || pc !== 64'h0) begin
            tests_failed++;
            $display("FAIL start_latency: pc=%h valid=%b want pc=0 valid=1", pc, pc_valid);
        end
        tick();
        tests_run++;
        if (pc !== 64'h4) begin
            tests_failed++;
            $display("FAIL seq_4: pc=%h want 4", pc);
        end
        tick();
        tests_run++;
        if (pc !== 64'h8) begin
            tests_failed++;
            $display("FAIL seq_8: pc=%h want 8", pc);
        end
    endtask

    task automatic test_stall();
        tick(); tick();
        tests_run++;
        if (pc !== 64'h10) begin
            tests_failed++;
            $display("FAIL reach_10: pc=%h want 10", pc);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (pc !== 64'h10 || pc_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h valid=%b want pc=10 valid=1", i, pc, pc_valid);
            end
        end
        stall = 1'b0;
        tick();
        tests_run++;
        if (pc !== 64'h14) begin
            tests_failed++;
            $display("FAIL stall_release: pc=%h want 14", pc);
        end
    endtask

    task automatic test_pending();
        tick(); tick(); tick();
        tests_run++;
        if (pc !== 64'h20) begin
            tests_failed++;
            $display("FAIL reach_20: pc=%h want 20", pc);
        end
        if_ready = 1'b0; br_taken = 1'b1; br_target = 64'h100;
        tick();
        tests_run++;
        if (pc !== 64'h20 || redirect !== 1'b0 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL pend_hold1: pc=%h redir=%b valid=%b want pc=20 redir=0 valid=1",
                     pc, redirect, pc_valid);
        end
        br_target = 64'h200;
        tick();
        tests_run++;
        if (pc !== 64'h20 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_hold2: pc=%h redir=%b want pc=20 redir=0", pc, redirect);
        end
        br_taken = 1'b0; if_ready = 1'b1;
        tick();
        tests_run++;
        if (pc !== 64'h200 || redirect !== 1'b1 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_load: pc=%h redir=%b mis=%b want pc=200 redir=1 mis=0",
                     pc, redirect, misalign_err);
        end
        tick();
        tests_run++;
        if (pc !== 64'h204 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_after: pc=%h redir=%b want pc=204 redir=0", pc, redirect);
        end
    endtask

    task automatic test_priority();
        trap_taken = 1'b1; trap_target = 64'h8000;
        br_taken = 1'b1; br_target = 64'h100; stall = 1'b1;
        tick();
        trap_taken = 1'b0; br_taken = 1'b0;
        tests_run++;
        if (pc !== 64'h8000 || redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL trap_over_br: pc=%h redir=%b want pc=8000 redir=1", pc, redirect);
        end
        tick();
        tests_run++;
        if (pc !== 64'h8000 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_after_trap: pc=%h redir=%b want pc=8000 redir=0", pc, redirect);
        end
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        logic [XLEN-1:0] exp_pc;
        logic            exp_mis;
`ifdef PC_GEN_RVC_EN
        exp_pc = 64'h102; exp_mis = 1'b0;
`else
        exp_pc = 64'h100; exp_mis = 1'b1;
`endif
        br_taken = 1'b1; br_target = 64'h102;
        tick();
        br_taken = 1'b0; is_rvc = 1'b1;
        tests_run++;
        if (pc !== exp_pc || misalign_err !== exp_mis || redirect !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_load: pc=%h mis=%b redir=%b want pc=%h mis=%b redir=1",
                     pc, misalign_err, redirect, exp_pc, exp_mis);
        end
        tick();
        is_rvc = 1'b0;
        tests_run++;
        if (pc !== 64'h104 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_next: pc=%h mis=%b want pc=104 mis=0", pc, misalign_err);
        end
    endtask

    task automatic test_wrap();
        br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        br_taken = 1'b0;
        tests_run++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_load: pc=%h mis=%b want pc=fffffffffffffffc mis=0", pc, misalign_err);
        end
        tick();
        tests_run++;
        if (pc !== 64'h0) begin
            tests_failed++;
            $display("FAIL wrap: pc=%h want 0", pc);
        end
    endtask

    task automatic test_halt();
        tick();
        tests_run++;
        if (pc !== 64'h4) begin
            tests_failed++;
            $display("FAIL pre_halt: pc=%h want 4", pc);
        end
        halt = 1'b1; start = 1'b1;
        tick();
        halt = 1'b0; start = 1'b0;
        tests_run++;
        if (pc_valid !== 1'b0 || pc !== 64'h4) begin
            tests_failed++;
            $display("FAIL halt_prio: pc=%h valid=%b want pc=4 valid=0", pc, pc_valid);
        end
        br_taken = 1'b1; br_target = 64'h300;
        tick();
        br_taken = 1'b0;
        tests_run++;
        if (pc !== 64'h4 || redirect !== 1'b0 || pc_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_ignore_br: pc=%h redir=%b valid=%b want pc=4 redir=0 valid=0",
                     pc, redirect, pc_valid);
        end
        start = 1'b1; halt = 1'b1;
        tick();
        start = 1'b0; halt = 1'b0;
        tests_run++;
        if (pc_valid !== 1'b1 || pc !== 64'h4) begin
            tests_failed++;
            $display("FAIL restart: pc=%h valid=%b want pc=4 valid=1", pc, pc_valid);
        end
        tick();
        tests_run++;
        if (pc !== 64'h8) begin
            tests_failed++;
            $display("FAIL restart_adv: pc=%h want 8", pc);
        end
    endtask

    task automatic test_reset_mid_run();
        if_ready = 1'b0; br_taken = 1'b1; br_target = 64'h400;
        tick();
        br_taken = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (pc !== 64'h0 || pc_valid !== 1'b0 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: pc=%h valid=%b redir=%b want pc=0 valid=0 redir=0",
                     pc, pc_valid, redirect);
        end
        @(negedge clk);
        rstn = 1'b1;
        start = 1'b1; if_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if (pc !== 64'h4 || redirect !== 1'b0) begin
            tests_failed++;
            $display("FAIL pend_cleared: pc=%h redir=%b want pc=4 redir=0", pc, redirect);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_start();
        test_stall();
        test_pending();
        test_priority();
        test_misalign();
        test_wrap();
        test_halt();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish, want completion before 20000");
        $fatal(1, "timeout");
    end

endmodule
